// File: rtl/sram_clip_mixer_pkg.sv
// Shared types and defaults for the SRAM clip mixer.
package clip_mix_pkg;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_ACC, S_OUT} state_t;

    localparam int          DEF_NUM_CLIPS   = 4;
    localparam int          DEF_ADDR_W      = 20;
    localparam logic [19:0] DEF_CLIP_LEN    = 20'h20000;
    localparam logic [19:0] DEF_BASE_ADDR   = 20'h20000;
    localparam logic [19:0] DEF_CLIP_STRIDE = 20'h20000;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] acc);
        if (acc > 32'sd32767)  return 16'sh7fff;
        if (acc < -32'sd32768) return 16'sh8000;
        return acc[15:0];
    endfunction

endpackage

// File: rtl/sram_clip_mixer_if.sv
// SRAM read port and mixed-sample output of the clip mixer.
interface sram_clip_mixer_if
    import clip_mix_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0]  o_sram_addr;
    logic               o_sram_rd;
    logic signed [15:0] i_sram_dq;
    logic signed [15:0] o_sample;
    logic               o_valid;

    modport master (output o_sram_addr, o_sram_rd, o_sample, o_valid, input i_sram_dq);
    modport slave  (input o_sram_addr, o_sram_rd, o_sample, o_valid, output i_sram_dq);
endinterface

// File: rtl/sram_clip_mixer.sv
// Per-frame multi-clip mixer: reads one sample per clip, shifts, sums with
// saturation, and owns the shared playback index with loop/stop control.
module sram_clip_mixer
    import clip_mix_pkg::*;
#(
    parameter int                NUM_CLIPS   = DEF_NUM_CLIPS,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] CLIP_LEN    = DEF_CLIP_LEN,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [ADDR_W-1:0] CLIP_STRIDE = DEF_CLIP_STRIDE
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_loop,
    input  logic                   i_frame_start,
    input  logic [NUM_CLIPS-1:0]   i_clip_en,
    input  logic [2*NUM_CLIPS-1:0] i_gain,
    sram_clip_mixer_if.master      bus,
    output logic                   o_wrap,
    output logic                   o_busy,
    output logic                   o_running,
    output logic                   o_overrun
);

    localparam int K_W   = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1;
    localparam int IDX_W = (CLIP_LEN > 1) ? $clog2(CLIP_LEN) : 1;
    localparam int ACC_W = 16 + $clog2(NUM_CLIPS);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_CLIPS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CLIP_LEN - 1);

    state_t                      state_q;
    logic [K_W-1:0]              k_q;
    logic [IDX_W-1:0]            idx_q;
    logic                        running_q;
    logic [NUM_CLIPS-1:0]        en_q;
    logic [NUM_CLIPS-1:0][1:0]   gain_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     acc_d;
    logic signed [ACC_W-1:0]     dq_ext;
    logic signed [ACC_W-1:0]     term;
    logic signed [31:0]          acc_wide;
    logic [ADDR_W-1:0]           addr_q;
    logic                        rd_q;
    logic                        valid_q;
    logic                        wrap_q;
    logic                        overrun_q;
    logic signed [15:0]          sample_q;

    function automatic logic [ADDR_W-1:0] clip_addr(input logic [K_W-1:0] k,
                                                     input logic [IDX_W-1:0] idx);
        return BASE_ADDR + ADDR_W'(k) * CLIP_STRIDE + ADDR_W'(idx);
    endfunction

    // Contribution of the clip whose data is on the bus during S_ACC.
    always_comb begin
        dq_ext = {{(ACC_W-16){bus.i_sram_dq[15]}}, bus.i_sram_dq};
        if (en_q[k_q]) term = dq_ext >>> gain_q[k_q];
        else           term = '0;
        acc_d    = acc_q + term;
        acc_wide = {{(32-ACC_W){acc_d[ACC_W-1]}}, acc_d};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            idx_q     <= '0;
            running_q <= 1'b0;
            en_q      <= '0;
            gain_q    <= '0;
            acc_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            overrun_q <= 1'b0;
            sample_q  <= '0;
        end else begin
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            overrun_q <= i_frame_start && (state_q != S_IDLE);
            if (i_stop) begin
                state_q   <= S_IDLE;
                running_q <= 1'b0;
                sample_q  <= '0;
                rd_q      <= 1'b0;
                addr_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            idx_q     <= '0;
                            running_q <= 1'b1;
                        end else if (i_frame_start && running_q) begin
                            en_q    <= i_clip_en;
                            gain_q  <= i_gain;
                            acc_q   <= '0;
                            k_q     <= '0;
                            state_q <= S_READ;
                            rd_q    <= 1'b1;
                            addr_q  <= clip_addr('0, idx_q);
                        end
                    end
                    S_READ: state_q <= S_ACC;
                    S_ACC: begin
                        acc_q <= acc_d;
                        if (k_q == K_LAST) begin
                            state_q  <= S_OUT;
                            rd_q     <= 1'b0;
                            addr_q   <= '0;
                            sample_q <= sat16(acc_wide);
                            valid_q  <= 1'b1;
                            wrap_q   <= (idx_q == IDX_LAST);
                        end else begin
                            k_q     <= k_q + K_W'(1);
                            state_q <= S_READ;
                            addr_q  <= clip_addr(k_q + K_W'(1), idx_q);
                        end
                    end
                    S_OUT: begin
                        state_q <= S_IDLE;
                        if (idx_q == IDX_LAST) begin
                            idx_q <= '0;
                            if (!i_loop) running_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_sram_addr = addr_q;
    assign bus.o_sram_rd   = rd_q;
    assign bus.o_sample    = sample_q;
    assign bus.o_valid     = valid_q;
    assign o_wrap          = wrap_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_running       = running_q;
    assign o_overrun       = overrun_q;

endmodule

// File: tb/tb_sram_clip_mixer.sv
// Directed and randomized bench for sram_clip_mixer against a frame-level model.
module tb_sram_clip_mixer;
    import clip_mix_pkg::*;

    localparam int          CLEN   = 4;
    localparam logic [19:0] BASE   = DEF_BASE_ADDR;
    localparam logic [19:0] STRIDE = DEF_CLIP_STRIDE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b1;
    logic       frame_start = 1'b0;
    logic [3:0] clip_en = 4'h0;
    logic [7:0] gain = 8'h00;
    logic       wrap, busy, running, overrun;

    sram_clip_mixer_if #(.ADDR_W(20)) bus ();

    logic signed [15:0] dq_vals [4];
    int checks = 0;
    int errors = 0;
    int m_idx = 0;
    bit m_run = 1'b0;

    sram_clip_mixer #(
        .NUM_CLIPS(4), .ADDR_W(20), .CLIP_LEN(20'd4),
        .BASE_ADDR(BASE), .CLIP_STRIDE(STRIDE)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
        .i_frame_start(frame_start), .i_clip_en(clip_en), .i_gain(gain),
        .bus(bus), .o_wrap(wrap), .o_busy(busy), .o_running(running),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    // SRAM: each clip region returns that clip's value for the current frame.
    always_comb begin
        logic [19:0] off;
        off = bus.o_sram_addr - BASE;
        bus.i_sram_dq = 16'sd0;
        if (bus.o_sram_rd && off[19:17] < 3'd4) bus.i_sram_dq = dq_vals[off[18:17]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int ref_mix(input logic [3:0] en, input logic [7:0] g);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++)
            if (en[k]) s += floor_div(int'(dq_vals[k]), 1 << g[2*k +: 2]);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic set_all(input int v);
        for (int k = 0; k < 4; k++) dq_vals[k] = 16'(v);
    endtask

    task automatic set_rand();
        for (int k = 0; k < 4; k++) dq_vals[k] = 16'($urandom_range(0, 65535));
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_run = 1'b1;
        m_idx = 0;
        check_b("start_running", running, 1'b1);
    endtask

    task automatic dead_frame();
        int bad;
        bad = 0;
        clip_en = 4'hF;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (bus.o_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) bad++;
            tick();
        end
        check_w("dead_frame", 32'(bad), 32'd0);
    endtask

    // inj: cycle for an extra frame_start; stop_at: cycle for i_stop (0 = none).
    task automatic do_frame(input logic [3:0] en, input logic [7:0] g,
                            input int inj, input int stop_at);
        int          exp_s;
        int          bad;
        logic [19:0] exp_addr;
        exp_s = ref_mix(en, g);
        clip_en = en;
        gain = g;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                exp_addr = BASE + 20'((c - 1) / 2) * STRIDE + 20'(m_idx);
                check_b("sram_rd", bus.o_sram_rd, 1'b1);
                check_w("sram_addr", 32'(bus.o_sram_addr), 32'(exp_addr));
                check_b("valid_early", bus.o_valid, 1'b0);
            end else begin
                check_b("valid", bus.o_valid, 1'b1);
                check_w("sample", 32'(bus.o_sample), 32'(exp_s));
                check_b("wrap", wrap, m_idx == CLEN - 1);
                check_b("rd_out", bus.o_sram_rd, 1'b0);
            end
            check_b("busy", busy, 1'b1);
            check_b("overrun", overrun, (inj > 0) && (c == inj + 1));
            frame_start = (c == inj);
            stop = (c == stop_at);
            tick();
            frame_start = 1'b0;
            if (c == stop_at) begin
                stop = 1'b0;
                m_run = 1'b0;
                check_b("stop_busy", busy, 1'b0);
                check_b("stop_running", running, 1'b0);
                check_w("stop_sample", 32'(bus.o_sample), 32'd0);
                check_b("stop_rd", bus.o_sram_rd, 1'b0);
                bad = 0;
                for (int i = 0; i < 12; i++) begin
                    if (bus.o_valid !== 1'b0) bad++;
                    tick();
                end
                check_w("stop_quiet", 32'(bad), 32'd0);
                return;
            end
        end
        if (m_idx == CLEN - 1) begin
            m_idx = 0;
            if (!loop) m_run = 1'b0;
        end else begin
            m_idx++;
        end
        check_b("valid_after", bus.o_valid, 1'b0);
        check_b("busy_after", busy, 1'b0);
        check_b("running", running, m_run);
    endtask

    initial begin
        set_all(0);
        tick();
        tick();
        check_w("rst_sample", 32'(bus.o_sample), 32'd0);
        check_w("rst_addr", 32'(bus.o_sram_addr), 32'd0);
        check_b("rst_rd", bus.o_sram_rd, 1'b0);
        check_b("rst_valid", bus.o_valid, 1'b0);
        check_b("rst_wrap", wrap, 1'b0);
        check_b("rst_overrun", overrun, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_running", running, 1'b0);
        rst = 1'b0;
        tick();

        dead_frame();
        start_pulse();

        set_all(1000);
        do_frame(4'hF, 8'h00, 0, 0);
        set_all(20000);
        do_frame(4'hF, 8'h00, 0, 0);
        set_all(-20000);
        do_frame(4'hF, 8'h00, 0, 0);
        set_all(-64);
        do_frame(4'b0101, 8'hE4, 0, 0);
        set_rand();
        do_frame(4'hF, 8'h1B, 0, 0);

        loop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            do_frame(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 0, 0);
        end
        check_b("noloop_stopped", running, 1'b0);
        dead_frame();

        for (int n = 0; n < 14; n++) begin
            if (!m_run) start_pulse();
            loop = ($urandom_range(0, 3) != 0);
            set_rand();
            do_frame(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 0, 0);
        end

        loop = 1'b1;
        if (!m_run) start_pulse();
        set_rand();
        do_frame(4'hF, 8'($urandom_range(0, 255)), 3, 0);

        set_rand();
        do_frame(4'hF, 8'h00, 0, 4);
        dead_frame();

        start_pulse();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        m_run = 1'b0;
        check_b("start_stop_running", running, 1'b0);
        dead_frame();

        start_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_run = 1'b0;
        m_idx = 0;
        check_b("midrst_busy", busy, 1'b0);
        check_b("midrst_running", running, 1'b0);
        check_b("midrst_rd", bus.o_sram_rd, 1'b0);
        check_w("midrst_addr", 32'(bus.o_sram_addr), 32'd0);
        check_w("midrst_sample", 32'(bus.o_sample), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_clip_mixer.md
# sram_clip_mixer

Multi-clip playback mixer between the SRAM and the audio DAC path. Once per audio frame it reads one sample from each of NUM_CLIPS clips stored at fixed SRAM regions. It scales each enabled sample by a per-clip right-shift gain, sums with saturation, and presents one 16-bit signed sample with a valid pulse to the downstream player. It owns the shared playback index, including wrap and loop/stop control.

## Interface
- NUM_CLIPS, 4, number of clips mixed per frame
- ADDR_W, 20, SRAM word-address width
- CLIP_LEN, 20'h20000, samples per clip; index range 0..CLIP_LEN-1
- BASE_ADDR, 20'h20000, SRAM word address of clip 0, sample 0
- CLIP_STRIDE, 20'h20000, address distance between consecutive clips
- i_clk  in  1  system clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  pulse; begin playback from index 0
- i_stop  in  1  pulse; end playback, abort any frame in progress
- i_loop  in  1  1: wrap and continue at clip end; 0: stop at clip end
- i_frame_start  in  1  pulse, one per DAC frame; requests one mixed sample
- i_clip_en  in  NUM_CLIPS  per-clip enable, latched at frame start
- i_gain  in  2*NUM_CLIPS  per-clip arithmetic right shift 0..3; clip k uses bits [2k+1:2k]; latched at frame start
- o_sram_addr  out  ADDR_W  SRAM read address
- o_sram_rd  out  1  high while an address is being presented
- i_sram_dq  in  16  SRAM read data, signed
- o_sample  out  16  mixed signed sample, held between updates
- o_valid  out  1  one-cycle pulse when o_sample updates
- o_wrap  out  1  one-cycle pulse when the index wraps to 0
- o_busy  out  1  frame in progress
- o_running  out  1  playback active
- o_overrun  out  1  one-cycle pulse when i_frame_start arrives while busy

## Operation
- States:
  - S_IDLE → S_READ on i_frame_start when running. Clip_en and gain are latched; clip counter k = 0.
  - S_READ → S_ACC. Drives the address for clip k.
  - S_ACC → S_READ with k+1 if k < NUM_CLIPS-1, else → S_OUT. Drives the same address; i_sram_dq is sampled at the end of this cycle.
  - S_OUT → S_IDLE. Registers the saturated accumulator to o_sample, pulses o_valid, advances the index.
- Address is BASE_ADDR + k*CLIP_STRIDE + idx, truncated to ADDR_W. o_sram_rd = 1 in S_READ and S_ACC; otherwise o_sram_rd = 0 and o_sram_addr = 0.
- Accumulation:
  - Accumulator is 16+clog2(NUM_CLIPS) bits signed, cleared at frame start.
  - Each enabled clip adds sext(dq) >>> gain. Disabled clips still take their 2 cycles and add 0.
  - Output saturates to [-32768, 32767].
- Index update in S_OUT:
  - If idx == CLIP_LEN-1: idx becomes 0 and o_wrap pulses in that cycle. If i_loop = 0, running clears.
  - Otherwise idx increments by 1.
- i_start in S_IDLE: idx = 0, running = 1. i_start in any other state is ignored.
- i_stop in any state: running = 0, next state S_IDLE, o_sample = 0 next cycle, no o_valid.
- i_stop and i_start in the same cycle: stop wins.
- i_frame_start while running = 0: ignored; no o_valid, no overrun.
- i_frame_start while busy: ignored; o_overrun pulses.

## Timing
- Reset values:
  - State S_IDLE, idx 0, running 0.
  - Outputs: o_sample 0, o_valid/o_wrap/o_overrun/o_busy/o_running/o_sram_rd 0, o_sram_addr 0.
- Reset mid-frame returns to these values on the next edge.
- Frame latency, taking i_frame_start high in cycle 0:
  - Clip k occupies cycles 2k+1 (S_READ) and 2k+2 (S_ACC).
  - o_valid is high in cycle 2*NUM_CLIPS+1 (cycle 9 for 4 clips).
  - S_IDLE in cycle 2*NUM_CLIPS+2.
- o_busy = 1 in every state except S_IDLE.
- Minimum frame-start spacing without overrun: 2*NUM_CLIPS+2 cycles.
- o_running falls in the cycle after S_OUT when a non-looping clip ends, and in the cycle after i_stop.

## Structure
- Package clip_mix_pkg holds:
  - the state enum (S_IDLE, S_READ, S_ACC, S_OUT);
  - default address constants;
  - a function sat16(acc) that clamps to 16-bit signed.
- No sub-module. Counter, FSM and accumulator stay in one module.

## Test plan
- Start, frame_start, dq = 1000 for all clips, enables 4'hF, gains 0 → o_valid in cycle 9 with o_sample = 4000. Addresses seen: 20'h20000, 20'h40000, 20'h60000, 20'h80000.
- dq = 20000 on all clips, gain 0 → o_sample = 32767. dq = -20000 on all clips → o_sample = -32768.
- Enables 4'b0101, gains {3,2,1,0} (clip3..0), dq = -64 on all clips → o_sample = -64 + (-16) = -80.
- idx preset to CLIP_LEN-1 by running frames (shortened CLIP_LEN = 4):
  - i_loop = 1 → o_wrap on the 4th frame and next address offset 0.
  - i_loop = 0 → o_running = 0, and later frame_starts give no o_valid.
- frame_start in cycle 3 of a busy frame → o_overrun pulse, and the frame completes normally.
- i_stop in cycle 4 → S_IDLE next cycle, no o_valid, o_sample = 0. Same-cycle i_start+i_stop → o_running = 0.
